// File: rtl/mmio_timer_responder.sv
// Timer/LED MMIO responder on the CPU data-memory port: reload timer with overflow interrupt,
// LED register and (with MMIO_SYSTICK_EN defined) a free-running read-only SYSTICK counter.
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 Interrupt
);

  typedef enum logic [2:0] {
    OFF_TH      = 3'd0,
    OFF_TL      = 3'd1,
    OFF_TCON    = 3'd2,
    OFF_LED     = 3'd3,
    OFF_SYSTICK = 3'd4
  } reg_offset_e;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  logic [31:0]          th_q, th_d;
  logic [31:0]          tl_q, tl_d;
  logic [2:0]           tcon_q, tcon_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          read_data_q, read_data_d;
`ifdef MMIO_SYSTICK_EN
  logic [31:0]          systick_q, systick_d;
`endif

  logic        hit;
  logic [2:0]  offset;
  logic        wr_hit;
  logic        overflow;
  logic        set_is;
  logic [31:0] rd_mux;
  logic [1:0]  unused_addr_bits;

  assign hit              = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset           = Address[4:2];
  assign wr_hit           = MemWrite && hit;
  assign unused_addr_bits = Address[1:0];

  // Overflow only sets IS when IE was already enabled before this edge.
  assign overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
  assign set_is   = overflow && tcon_q[TCON_IE];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (offset)
        OFF_TH:      rd_mux = th_q;
        OFF_TL:      rd_mux = tl_q;
        OFF_TCON:    rd_mux[2:0] = tcon_q;
        OFF_LED:     rd_mux[LED_WIDTH-1:0] = led_q;
`ifdef MMIO_SYSTICK_EN
        OFF_SYSTICK: rd_mux = systick_q;
`endif
        default:     rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    read_data_d = MemRead ? rd_mux : read_data_q;
    th_d        = th_q;
    led_d       = led_q;

    // Count/reload first; a CPU store to TL below overrides it.
    if (!tcon_q[TCON_EN])  tl_d = tl_q;
    else if (overflow)     tl_d = th_q;
    else                   tl_d = tl_q + 32'd1;

    tcon_d = {tcon_q[TCON_IS] | set_is, tcon_q[TCON_IE], tcon_q[TCON_EN]};

    if (wr_hit) begin
      case (offset)
        OFF_TH:   th_d   = WriteData;
        OFF_TL:   tl_d   = WriteData;
        OFF_TCON: tcon_d = {WriteData[TCON_IS] | set_is, WriteData[TCON_IE], WriteData[TCON_EN]};
        OFF_LED:  led_d  = WriteData[LED_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

`ifdef MMIO_SYSTICK_EN
  assign systick_d = systick_q + 32'd1;
`endif

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q        <= '0;
      tl_q        <= '0;
      tcon_q      <= '0;
      led_q       <= '0;
      read_data_q <= '0;
`ifdef MMIO_SYSTICK_EN
      systick_q   <= '0;
`endif
    end else begin
      th_q        <= th_d;
      tl_q        <= tl_d;
      tcon_q      <= tcon_d;
      led_q       <= led_d;
      read_data_q <= read_data_d;
`ifdef MMIO_SYSTICK_EN
      systick_q   <= systick_d;
`endif
    end
  end

  assign ReadData  = read_data_q;
  assign leds      = led_q;
  assign Interrupt = tcon_q[TCON_IS];

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboard bench for mmio_timer_responder: directed scenarios plus random MMIO traffic
// checked against a register-level model of the timer/LED window.
module tb_mmio_timer_responder;

  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam int unsigned LED_W    = 8;
  localparam logic [31:0] LED_MASK = 32'h0000_00FF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [31:0]       Address = '0;
  logic [31:0]       WriteData = '0;
  logic [31:0]       ReadData;
  logic [LED_W-1:0]  leds;
  logic              Interrupt;

  mmio_timer_responder #(.BASE_ADDR(BASE), .LED_WIDTH(LED_W)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .leds(leds), .Interrupt(Interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] leds;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: register file values after the most recent modelled edge.
  logic [31:0] m_th, m_tl, m_led, m_sys, m_rd;
  logic        m_en, m_ie, m_is;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_led = '0; m_sys = '0; m_rd = '0;
    m_en = 1'b0; m_ie = 1'b0; m_is = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_is, m_ie, m_en};
      3'd3: return m_led;
`ifdef MMIO_SYSTICK_EN
      3'd4: return m_sys;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply one bus cycle's inputs now and record what the DUT must show after the next rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic        wrap, raise;
    logic [31:0] new_tl;
    logic        new_is;
    MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
    if (rd) m_rd = m_read(a);
    wrap   = m_en && (m_tl == 32'hFFFF_FFFF);
    raise  = wrap && m_ie;
    new_tl = m_en ? (wrap ? m_th : m_tl + 32'd1) : m_tl;
    new_is = m_is | raise;
    if (wr && a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: m_th = d;
        3'd1: new_tl = d;
        3'd2: begin m_en = d[0]; m_ie = d[1]; new_is = d[2] | raise; end
        3'd3: m_led = d & LED_MASK;
        default: ;
      endcase
    end
    m_tl  = new_tl;
    m_is  = new_is;
    m_sys = m_sys + 32'd1;
    e.rd = m_rd; e.leds = m_led; e.irq = m_is;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(rd, wr, a, d);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d); cyc(1'b0, 1'b1, a, d); endtask
  task automatic rd_reg(input logic [31:0] a);                      cyc(1'b1, 1'b0, a, '0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset in the middle of a clock phase, checked before any further edge.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_read_data", ReadData, 32'd0);
    check("async_reset_leds", {24'd0, leds}, 32'd0);
    check("async_reset_interrupt", {31'd0, Interrupt}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: each rising edge that follows a driven cycle consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("read_data", ReadData, e.rd);
        check("leds", {24'd0, leds}, e.leds);
        check("interrupt", {31'd0, Interrupt}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic        r, w;
    model_reset();
    #12;
    check("power_on_read_data", ReadData, 32'd0);
    check("power_on_leds", {24'd0, leds}, 32'd0);
    check("power_on_interrupt", {31'd0, Interrupt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);

    // Register read/write, unmapped offset and out-of-window accesses.
    wr_reg(BASE + 32'h0C, 32'h0000_00A5);
    rd_reg(BASE + 32'h0C);
    rd_reg(BASE + 32'h1C);
    wr_reg(BASE + 32'h1C, 32'hDEAD_BEEF);
    wr_reg(32'h5000_000C, 32'h0000_00FF);
    rd_reg(32'h5000_000C);
    rd_reg(BASE + 32'h0F);
    wr_reg(BASE + 32'h00, 32'h1234_5678);
    rd_reg(BASE + 32'h00);
    idle(1);

    // Overflow with reload and interrupt, then software clears IS.
    wr_reg(BASE + 32'h00, 32'h0000_0010);
    wr_reg(BASE + 32'h04, 32'hFFFF_FFFD);
    wr_reg(BASE + 32'h08, 32'h0000_0003);
    idle(2);
    rd_reg(BASE + 32'h04);
    idle(1);
    rd_reg(BASE + 32'h04);
    wr_reg(BASE + 32'h08, 32'h0000_0003);
    rd_reg(BASE + 32'h08);
    wr_reg(BASE + 32'h08, 32'h0000_0000);

    // Overflow with IE=0: reload without interrupt.
    wr_reg(BASE + 32'h00, 32'h0000_0000);
    wr_reg(BASE + 32'h04, 32'hFFFF_FFFF);
    wr_reg(BASE + 32'h08, 32'h0000_0001);
    rd_reg(BASE + 32'h04);
    rd_reg(BASE + 32'h08);
    wr_reg(BASE + 32'h08, 32'h0000_0000);

    // TCON write on the overflow edge: IS set wins over written 0.
    wr_reg(BASE + 32'h04, 32'hFFFF_FFFE);
    wr_reg(BASE + 32'h08, 32'h0000_0003);
    idle(1);
    wr_reg(BASE + 32'h08, 32'h0000_0003);
    rd_reg(BASE + 32'h08);
    // Clearing IE leaves IS set.
    wr_reg(BASE + 32'h08, 32'h0000_0005);
    rd_reg(BASE + 32'h08);
    wr_reg(BASE + 32'h08, 32'h0000_0000);

    // TL store on the overflow edge beats the reload; TH store on a reload edge.
    wr_reg(BASE + 32'h00, 32'h0000_0777);
    wr_reg(BASE + 32'h04, 32'hFFFF_FFFE);
    wr_reg(BASE + 32'h08, 32'h0000_0003);
    idle(1);
    wr_reg(BASE + 32'h04, 32'h0000_0055);
    wr_reg(BASE + 32'h04, 32'hFFFF_FFFF);
    wr_reg(BASE + 32'h00, 32'h0000_0999);
    rd_reg(BASE + 32'h04);
    rd_reg(BASE + 32'h00);
    wr_reg(BASE + 32'h08, 32'h0000_0000);
    idle(10);
    rd_reg(BASE + 32'h04);

    // Simultaneous load and store returns the old value.
    cyc(1'b1, 1'b1, BASE + 32'h04, 32'h0000_1234);
    rd_reg(BASE + 32'h04);

    // SYSTICK (or zero when absent): reads five cycles apart, store ignored.
    rd_reg(BASE + 32'h10);
    idle(4);
    rd_reg(BASE + 32'h10);
    wr_reg(BASE + 32'h10, 32'h0000_0000);
    rd_reg(BASE + 32'h10);

    // Random traffic, biased towards the window and towards TL values near wrap.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) != 0) a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      else                           a = $urandom;
      d = $urandom;
      if (a[4:2] == 3'd1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + {28'd0, 4'($urandom_range(0, 15))};
      if (a[4:2] == 3'd2 && $urandom_range(0, 3) != 0) d = {29'd0, 3'($urandom_range(0, 7)) | 3'b001};
      cyc(r, w, a, d);
    end

    wr_reg(BASE + 32'h0C, 32'h0000_003C);
    wr_reg(BASE + 32'h08, 32'h0000_0007);
    mid_cycle_reset();
    rd_reg(BASE + 32'h04);
    rd_reg(BASE + 32'h08);
    idle(3);
    rd_reg(BASE + 32'h04);

    idle(1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
